// File: rtl/timebase_counter.sv
// Prescaled PWM timebase: up, down, up-down and one-shot counting with registered event pulses.
// Optional shadowed period: define TIMEBASE_SHADOW_PERIOD_EN.
module timebase_counter #(
  parameter int CNT_W     = 16,
  parameter int PRESC_W   = 8,
  parameter int MAX_SHIFT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               count_reset,
  input  logic [1:0]         mode,
  input  logic [PRESC_W-1:0] prescale,
  input  logic [CNT_W-1:0]   period,
  output logic [CNT_W-1:0]   count_val,
  output logic               dir,
  output logic               ovf_pulse,
  output logic               unf_pulse,
  output logic               running
);

  typedef enum logic [1:0] {
    MODE_UP      = 2'b00,
    MODE_DOWN    = 2'b01,
    MODE_UPDN    = 2'b10,
    MODE_ONESHOT = 2'b11
  } mode_e;

  localparam int PS_W = (MAX_SHIFT > 0) ? MAX_SHIFT : 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [PS_W-1:0]  PS_ONE  = PS_W'(1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_dir;
  logic             r_done;
  logic             r_ovf;
  logic             r_unf;
  logic [PS_W-1:0]  r_presc;

  logic [CNT_W-1:0] w_period;
  logic [31:0]      w_shift;
  logic [PS_W:0]    w_one;
  logic [PS_W:0]    w_term;
  logic             w_step;
  logic [CNT_W-1:0] w_cnt_nx;
  logic             w_dir_nx;
  logic             w_done_nx;
  logic             w_ovf_nx;
  logic             w_unf_nx;
  logic             w_reload;

  // >= rather than == so a prescale reduction mid-count steps at once instead of wrapping.
  assign w_shift = (32'(prescale) > 32'(MAX_SHIFT)) ? 32'(MAX_SHIFT) : 32'(prescale);
  assign w_one   = {{PS_W{1'b0}}, 1'b1} << w_shift;
  assign w_term  = w_one - {{PS_W{1'b0}}, 1'b1};
  assign w_step  = ({1'b0, r_presc} >= w_term);

  always_comb begin
    w_cnt_nx  = r_cnt;
    w_dir_nx  = r_dir;
    w_done_nx = r_done;
    w_ovf_nx  = 1'b0;
    w_unf_nx  = 1'b0;
    w_reload  = 1'b0;
    case (mode)
      MODE_UP: begin
        w_dir_nx = 1'b1;
        if (r_cnt >= w_period) begin
          w_cnt_nx = '0;
          w_ovf_nx = 1'b1;
          w_reload = 1'b1;
        end else begin
          w_cnt_nx = r_cnt + CNT_ONE;
        end
      end
      MODE_DOWN: begin
        w_dir_nx = 1'b0;
        if (r_cnt == '0) begin
          w_cnt_nx = period;
          w_unf_nx = 1'b1;
          w_reload = 1'b1;
        end else begin
          w_cnt_nx = r_cnt - CNT_ONE;
        end
      end
      MODE_UPDN: begin
        if (w_period == '0) begin
          w_cnt_nx = '0;
          w_dir_nx = 1'b1;
          w_ovf_nx = 1'b1;
        end else if (r_dir) begin
          if (r_cnt >= w_period) begin
            w_dir_nx = 1'b0;
            w_cnt_nx = w_period - CNT_ONE;
            w_ovf_nx = 1'b1;
          end else begin
            w_cnt_nx = r_cnt + CNT_ONE;
          end
        end else if (r_cnt == '0) begin
          w_dir_nx = 1'b1;
          w_cnt_nx = CNT_ONE;
          w_unf_nx = 1'b1;
          w_reload = 1'b1;
        end else begin
          w_cnt_nx = r_cnt - CNT_ONE;
        end
      end
      default: begin
        // One-shot: once done, steps are ignored until a clear.
        if (!r_done) begin
          if (r_cnt >= w_period) begin
            w_cnt_nx  = w_period;
            w_ovf_nx  = 1'b1;
            w_done_nx = 1'b1;
          end else begin
            w_cnt_nx = r_cnt + CNT_ONE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_dir   <= 1'b1;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
      r_presc <= '0;
    end else if (count_reset) begin
      r_cnt   <= '0;
      r_dir   <= 1'b1;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
      r_presc <= '0;
    end else if (!en) begin
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
      r_presc <= '0;
    end else if (w_step) begin
      r_cnt   <= w_cnt_nx;
      r_dir   <= w_dir_nx;
      r_done  <= w_done_nx;
      r_ovf   <= w_ovf_nx;
      r_unf   <= w_unf_nx;
      r_presc <= '0;
    end else begin
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
      r_presc <= r_presc + PS_ONE;
    end
  end

`ifdef TIMEBASE_SHADOW_PERIOD_EN
  // Shadow only reloads at cycle boundaries so a mid-cycle write never truncates a cycle.
  logic [CNT_W-1:0] r_period;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_period <= '0;
    end else if (count_reset || !en || (w_step && w_reload)) begin
      r_period <= period;
    end
  end

  assign w_period = r_period;
`else
  logic w_reload_unused;

  assign w_period        = period;
  assign w_reload_unused = w_reload;
`endif

  assign count_val = r_cnt;
  assign dir       = r_dir;
  assign ovf_pulse = r_ovf;
  assign unf_pulse = r_unf;
  assign running   = en && !r_done;

endmodule

// File: tb/tb_timebase_counter.sv
// Directed bench for timebase_counter: reset, all four modes, prescale clamp, en hold, shadow period.
module tb_timebase_counter;

  localparam int CNT_W   = 16;
  localparam int PRESC_W = 8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               en;
  logic               count_reset;
  logic [1:0]         mode;
  logic [PRESC_W-1:0] prescale;
  logic [CNT_W-1:0]   period;
  logic [CNT_W-1:0]   count_val;
  logic               dir;
  logic               ovf_pulse;
  logic               unf_pulse;
  logic               running;

  int n_cmp = 0;
  int n_err = 0;

  int up_cnt[6]   = '{1, 2, 3, 4, 0, 1};
  int ud_cnt[7]   = '{1, 2, 3, 2, 1, 0, 1};
  int ud_dir[7]   = '{1, 1, 1, 0, 0, 0, 1};
  int dn_cnt[5]   = '{3, 2, 1, 0, 3};
  int os_cnt[6]   = '{1, 2, 3, 4, 5, 5};
`ifdef TIMEBASE_SHADOW_PERIOD_EN
  int sh_cnt[7]   = '{6, 7, 8, 0, 1, 2, 0};
  int sh_ovf[7]   = '{0, 0, 0, 1, 0, 0, 1};
`else
  int sh_cnt[4]   = '{0, 1, 2, 0};
  int sh_ovf[4]   = '{1, 0, 0, 1};
`endif

  always #5 clk = ~clk;

  timebase_counter #(
    .CNT_W     (CNT_W),
    .PRESC_W   (PRESC_W),
    .MAX_SHIFT (15)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .count_reset (count_reset),
    .mode        (mode),
    .prescale    (prescale),
    .period      (period),
    .count_val   (count_val),
    .dir         (dir),
    .ovf_pulse   (ovf_pulse),
    .unf_pulse   (unf_pulse),
    .running     (running)
  );

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int n_ovf;
    rst_n       = 1'b0;
    en          = 1'b0;
    count_reset = 1'b0;
    mode        = 2'b00;
    prescale    = '0;
    period      = 16'd4;
    tick(2);
    check("rst_cnt", count_val, 0);
    check("rst_dir", dir, 1);
    check("rst_ovf", ovf_pulse, 0);
    check("rst_unf", unf_pulse, 0);
    check("rst_running", running, 0);
    rst_n = 1'b1;

    // Up mode, S=0, period 4: 5-clock cycle, ovf with the 0.
    en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("up_cnt%0d", i), count_val, up_cnt[i]);
      check($sformatf("up_ovf%0d", i), ovf_pulse, (i == 4) ? 1 : 0);
      check($sformatf("up_unf%0d", i), unf_pulse, 0);
    end
    check("up_running", running, 1);

    // Prescale 2: each value held 4 clocks.
    count_reset = 1'b1;
    tick();
    check("clr_cnt", count_val, 0);
    count_reset = 1'b0;
    prescale    = 8'd2;
    period      = 16'd2;
    for (int i = 1; i <= 12; i++) begin
      tick();
      check($sformatf("ps2_cnt%0d", i), count_val, (i / 4) % 3);
      check($sformatf("ps2_ovf%0d", i), ovf_pulse, (i == 12) ? 1 : 0);
    end

    // Prescale 40 clamps to 15: first step 32768 clocks after clear.
    count_reset = 1'b1;
    period      = 16'd4;
    prescale    = 8'd40;
    tick();
    count_reset = 1'b0;
    tick(32767);
    check("clamp_before", count_val, 0);
    tick();
    check("clamp_step", count_val, 1);

    // Up-down, period 3.
    count_reset = 1'b1;
    prescale    = 8'd0;
    period      = 16'd3;
    mode        = 2'b10;
    tick();
    count_reset = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      check($sformatf("ud_cnt%0d", i), count_val, ud_cnt[i]);
      check($sformatf("ud_dir%0d", i), dir, ud_dir[i]);
      check($sformatf("ud_ovf%0d", i), ovf_pulse, (i == 3) ? 1 : 0);
      check($sformatf("ud_unf%0d", i), unf_pulse, (i == 6) ? 1 : 0);
    end

    // Down, period 3 from 0.
    count_reset = 1'b1;
    mode        = 2'b01;
    tick();
    count_reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("dn_cnt%0d", i), count_val, dn_cnt[i]);
      check($sformatf("dn_dir%0d", i), dir, 0);
      check($sformatf("dn_unf%0d", i), unf_pulse, (i == 0 || i == 4) ? 1 : 0);
      check($sformatf("dn_ovf%0d", i), ovf_pulse, 0);
    end
    tick();
    check("dn_cnt_pre_hold", count_val, 2);
    // Leave the prescaler part-way, then drop en: it must restart from 0.
    prescale = 8'd1;
    tick();
    check("dn_ps1_nostep", count_val, 2);
    en = 1'b0;
    tick(3);
    check("hold_cnt", count_val, 2);
    check("hold_dir", dir, 0);
    check("hold_running", running, 0);
    check("hold_unf", unf_pulse, 0);
    en = 1'b1;
    tick();
    check("resume_first", count_val, 2);
    tick();
    check("resume_step", count_val, 1);

    // One-shot, period 5.
    count_reset = 1'b1;
    mode        = 2'b11;
    prescale    = 8'd0;
    period      = 16'd5;
    tick();
    count_reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("os_cnt%0d", i), count_val, os_cnt[i]);
      check($sformatf("os_ovf%0d", i), ovf_pulse, (i == 5) ? 1 : 0);
    end
    check("os_running_done", running, 0);
    n_ovf = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ovf_pulse) n_ovf++;
    end
    check("os_extra_ovf", n_ovf, 0);
    check("os_hold_cnt", count_val, 5);
    check("os_hold_running", running, 0);
    count_reset = 1'b1;
    tick();
    check("os_clr_cnt", count_val, 0);
    check("os_clr_running", running, 1);
    count_reset = 1'b0;

    // Period 8 -> 2 at count 5.
    mode        = 2'b00;
    period      = 16'd8;
    count_reset = 1'b1;
    tick();
    count_reset = 1'b0;
    tick(5);
    check("sh_at5", count_val, 5);
    period = 16'd2;
    for (int i = 0; i < $size(sh_cnt); i++) begin
      tick();
      check($sformatf("sh_cnt%0d", i), count_val, sh_cnt[i]);
      check($sformatf("sh_ovf%0d", i), ovf_pulse, sh_ovf[i]);
    end
    tick();
    check("pre_async_cnt", count_val, 1);

    // Asynchronous reset mid-cycle.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_cnt", count_val, 0);
    check("async_rst_dir", dir, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
